// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Imported by the arbiter top and by its wait-counter watchdog.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_WORD       = 2'b10;
  localparam int         TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-cycle counter for a granted access. expired flags the wait cycle
// whose increment would bring the count up to TIMEOUT.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory port, alternating on ties and aborting accesses that never ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic        err
);

  arb_state_e  state_q, state_d;
  grant_e      last_q, last_d;
  logic        m_write_q, m_write_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_n_q, i_ack_n_d;
  logic        d_ack_n_q, d_ack_n_d;
  logic        err_q, err_d;

  logic granted, wd_expired, done, i_live, d_live;

  assign granted = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
  assign done    = !m_ack_n || wd_expired;
  // A request is still held high during its own ack cycle; it is stale then.
  assign i_live  = i_req && i_ack_n_q;
  assign d_live  = d_req && d_ack_n_q;

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_IDLE),
    .en      (granted && m_ack_n),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_n_d = 1'b1;
    d_ack_n_d = 1'b1;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_live && (!i_live || last_q == GRANT_I)) begin
          state_d   = ST_GNT_D;
          m_write_d = d_write;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (i_live) begin
          state_d   = ST_GNT_I;
          m_write_d = 1'b0;
          m_size_d  = SIZE_WORD;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (done) begin
          state_d = ST_IDLE;
          err_d   = m_ack_n;
          if (state_q == ST_GNT_I) begin
            last_d    = GRANT_I;
            i_ack_n_d = 1'b0;
            i_rdata_d = m_ack_n ? 32'h0 : m_rdata;
          end else begin
            last_d    = GRANT_D;
            d_ack_n_d = 1'b0;
            d_rdata_d = m_ack_n ? 32'h0 : m_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= GRANT_I;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_n_q <= i_ack_n_d;
      d_ack_n_q <= d_ack_n_d;
      err_q     <= err_d;
    end
  end

  assign m_req   = granted;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack_n = i_ack_n_q;
  assign d_ack_n = d_ack_n_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        i_req, d_req, d_write, m_ack_n;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack_n, d_ack_n, m_req, m_write, err;
  logic [1:0]  m_size;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks on the ack_after-th granted cycle (0 = never).
  int          ack_after = 1;
  int          gcnt = 0;
  logic [31:0] rdata_val = 32'h0;
  logic        idle_ack = 1'b1;
  always @(posedge clk) begin
    #1;
    if (m_req) begin
      gcnt++;
      m_ack_n = !(ack_after != 0 && gcnt == ack_after);
      m_rdata = rdata_val;
    end else begin
      gcnt    = 0;
      m_ack_n = idle_ack;
      m_rdata = 32'hDEAD_BEEF;
    end
  end

  // Transaction-level model: who owns the port, how long it has waited.
  int          owner;      // 0 none, 1 fetch, 2 data
  int          waited;
  bit          last_data;
  bit          iw, dw, fin, tout;
  logic        e_write, e_i_ack_n, e_d_ack_n, e_err;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata, val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; waited = 0; last_data = 1'b0;
      e_write = 1'b0; e_size = 2'b00; e_addr = 32'h0; e_wdata = 32'h0;
      e_i_rdata = 32'h0; e_d_rdata = 32'h0;
      e_i_ack_n = 1'b1; e_d_ack_n = 1'b1; e_err = 1'b0;
    end else begin
      iw = i_req && e_i_ack_n;
      dw = d_req && e_d_ack_n;
      e_i_ack_n = 1'b1; e_d_ack_n = 1'b1; e_err = 1'b0;
      if (owner == 0) begin
        if (dw && (!iw || !last_data)) begin
          owner = 2; waited = 0;
          e_write = d_write; e_size = d_size; e_addr = d_addr; e_wdata = d_wdata;
        end else if (iw) begin
          owner = 1; waited = 0;
          e_write = 1'b0; e_size = 2'b10; e_addr = i_addr;
        end
      end else begin
        fin = 1'b0; tout = 1'b0;
        if (!m_ack_n) fin = 1'b1;
        else begin
          waited++;
          if (waited >= TO) begin fin = 1'b1; tout = 1'b1; end
        end
        if (fin) begin
          val = tout ? 32'h0 : m_rdata;
          if (owner == 1) begin e_i_ack_n = 1'b0; e_i_rdata = val; end
          else begin e_d_ack_n = 1'b0; e_d_rdata = val; end
          e_err = tout;
          last_data = (owner == 2);
          owner = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req", m_req, owner != 0);
      if (owner != 0) begin
        chk("m_write", m_write, e_write);
        chk("m_size", m_size, e_size);
        chk("m_addr", m_addr, e_addr);
        if (owner == 2) chk("m_wdata", m_wdata, e_wdata);
      end
      chk("i_ack_n", i_ack_n, e_i_ack_n);
      chk("d_ack_n", d_ack_n, e_d_ack_n);
      chk("err", err, e_err);
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
    end
  end

  // Stimulus bookkeeping
  int cyc = 0;
  int t0, d_cnt0, ack_cnt0;
  int d_ack_cnt = 0, i_ack_cnt = 0;
  int d_ack_cyc = -1, i_ack_cyc = -1, err_cyc = -1;
  bit d_seen = 1'b0, i_seen = 1'b0, auto_drop = 1'b1;
  bit ack_q[$];

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (auto_drop) begin
      if (d_seen) begin d_req = 1'b0; d_seen = 1'b0; end
      if (i_seen) begin i_req = 1'b0; i_seen = 1'b0; end
    end
    @(negedge clk);
    if (d_ack_n === 1'b0) begin d_seen = 1'b1; d_ack_cnt++; d_ack_cyc = cyc; ack_q.push_back(1'b1); end
    if (i_ack_n === 1'b0) begin i_seen = 1'b1; i_ack_cnt++; i_ack_cyc = cyc; ack_q.push_back(1'b0); end
    if (err === 1'b1) err_cyc = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_req"}, m_req, 1'b0);
    chk({tag, "_m_write"}, m_write, 1'b0);
    chk({tag, "_m_size"}, m_size, 2'b00);
    chk({tag, "_m_addr"}, m_addr, 32'h0);
    chk({tag, "_m_wdata"}, m_wdata, 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_i_ack_n"}, i_ack_n, 1'b1);
    chk({tag, "_d_ack_n"}, d_ack_n, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_size = 2'b00;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_ack_n = 1'b1; m_rdata = 32'h0;
    repeat (2) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Simultaneous requests after reset: data first, fetch one cycle after the ack
    ack_after = 1; rdata_val = 32'h0000_1111;
    d_write = 1'b0; d_size = 2'b10; d_addr = 32'h1000; i_addr = 32'h0040;
    d_req = 1'b1; i_req = 1'b1; t0 = cyc; ack_q.delete();
    repeat (6) step();
    chk("tie_d_ack_cyc", d_ack_cyc, t0 + 2);
    chk("tie_i_ack_cyc", i_ack_cyc, t0 + 4);
    chk("tie_order_n", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      chk("tie_first_is_d", ack_q[0], 1'b1);
      chk("tie_second_is_i", ack_q[1], 1'b0);
    end

    // Fetch only, ack on the third granted cycle
    i_addr = 32'h100; rdata_val = 32'h0000_0013; ack_after = 3;
    d_cnt0 = d_ack_cnt; i_req = 1'b1; t0 = cyc;
    step();
    chk("f_m_req", m_req, 1'b1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_size", m_size, 2'b10);
    chk("f_m_write", m_write, 1'b0);
    repeat (3) step();
    chk("f_ack_cyc", i_ack_cyc, t0 + 4);
    chk("f_i_rdata", i_rdata, 32'h13);
    repeat (3) step();
    chk("f_d_ack_none", d_ack_cnt, d_cnt0);

    // Byte store, ack on the second granted cycle
    d_write = 1'b1; d_size = 2'b00; d_addr = 32'h2003; d_wdata = 32'hAB;
    rdata_val = 32'h0000_0055; ack_after = 2; ack_cnt0 = i_ack_cnt;
    d_req = 1'b1; t0 = cyc;
    step();
    chk("s_m_write", m_write, 1'b1);
    chk("s_m_size", m_size, 2'b00);
    chk("s_m_addr", m_addr, 32'h2003);
    chk("s_m_wdata", m_wdata, 32'hAB);
    step();
    chk("s_m_hold", m_wdata, 32'hAB);
    step();
    chk("s_ack_cyc", d_ack_cyc, t0 + 3);
    repeat (3) step();
    chk("s_i_ack_none", i_ack_cnt, ack_cnt0);

    // Fetch timeout: memory never acks
    i_addr = 32'h300; ack_after = 0; i_req = 1'b1; t0 = cyc;
    repeat (5) step();
    chk("to_ack_cyc", i_ack_cyc, t0 + 5);
    chk("to_err_cyc", err_cyc, t0 + 5);
    chk("to_i_rdata", i_rdata, 32'h0);
    chk("to_d_rdata_kept", d_rdata, 32'h55);
    chk("to_idle", m_req, 1'b0);
    step();
    chk("to_err_drop", err, 1'b0);
    repeat (2) step();

    // m_ack_n pulled low while idle must have no effect
    idle_ack = 1'b0; ack_cnt0 = i_ack_cnt + d_ack_cnt;
    repeat (3) step();
    chk("idle_acks", i_ack_cnt + d_ack_cnt, ack_cnt0);
    chk("idle_err", err, 1'b0);
    idle_ack = 1'b1;

    // Fairness: both held high across 10 accesses
    auto_drop = 1'b0; ack_q.delete(); ack_after = 1; rdata_val = 32'h0000_7777;
    d_write = 1'b0; d_size = 2'b10; d_addr = 32'h500; i_addr = 32'h600;
    d_req = 1'b1; i_req = 1'b1;
    repeat (20) step();
    d_req = 1'b0; i_req = 1'b0;
    chk("fair_count", ack_q.size(), 10);
    for (int k = 0; k < ack_q.size(); k++) chk($sformatf("fair_%0d", k), ack_q[k], (k % 2) == 0);
    auto_drop = 1'b1; d_seen = 1'b0; i_seen = 1'b0;
    repeat (2) step();

    // Reset in the middle of a data access
    d_addr = 32'h400; ack_after = 0; d_req = 1'b1; d_cnt0 = d_ack_cnt; ack_cnt0 = err_cyc;
    step();
    chk("r_granted", m_req, 1'b1);
    chk("r_m_addr", m_addr, 32'h400);
    #2 rst_n = 1'b0;
    d_req = 1'b0;
    #1 chk_reset_vals("mid");
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("r_no_d_ack", d_ack_cnt, d_cnt0);
    chk("r_no_err", err_cyc, ack_cnt0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
